dma_pcie_mi_4bx2048_ram_slv: RTL
================================

DMA_PCIE_MI_4BX2048_RAM_SLV -- requirements
Module: dma_pcie_mi_4bx2048_ram_slv

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning ren-to-rdat latency in clocks; legal values are 1 and 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port ram, the s modport of dma_pcie_mi_4Bx2048_4Bwe_ram_if, carrying the signals in REQ-005 to REQ-014.
REQ-005 SHALL have port ram.wadr, input, 12, write word address.
REQ-006 SHALL have port ram.wen, input, 1, write strobe; one 32-bit word per cycle.
REQ-007 SHALL have port ram.wdat, input, 32, write data.
REQ-008 SHALL have port ram.wpar, input, 8, write parity; bit i covers wdat[4i+3:4i], even parity.
REQ-009 SHALL have port ram.ren, input, 1, read strobe.
REQ-010 SHALL have port ram.radr, input, 12, read word address.
REQ-011 SHALL have port ram.rdat, output, 32, read data.
REQ-012 SHALL have port ram.rpar, output, 8, stored parity for rdat.
REQ-013 SHALL have port ram.rsbe, output, 1, single-bit parity error flag, valid with rdat.
REQ-014 SHALL have port ram.rdbe, output, 1, multi-bit parity error flag, valid with rdat.
REQ-015 SHALL have port init_done, output, 1; high once the memory clear has completed.

Function
REQ-016 SHALL store 2048 entries of 40 bits (32 data + 8 parity), indexed by adr[10:0].
REQ-017 SHALL treat an address with adr[11]=1 as out of range: writes are dropped, and reads return rdat=0, rpar=0, rsbe=0, rdbe=0.
REQ-018 SHALL implement an FSM with states INIT and READY; state after reset is INIT.
REQ-019 INIT SHALL write 0 data / 0 parity to entries 0..2047 using an 11-bit counter, one entry per clock.
REQ-020 SHALL move from INIT to READY on the clock after entry 2047 is written, with init_done registered high in READY (2048 clocks after rst_n deasserts).
REQ-021 While in INIT, SHALL ignore wen; a ren issued in INIT SHALL return all-zero outputs after RD_LAT.
REQ-022 A ren sampled at edge T SHALL present data on rdat/rpar/rsbe/rdbe after edge T+RD_LAT; RD_LAT=2 adds one output register stage.
REQ-023 Read outputs SHALL hold their value until the next read result is presented.
REQ-024 Back-to-back ren every cycle SHALL be supported at full throughput with results in issue order.
REQ-025 On wen and ren to the same in-range address in the same cycle, the read SHALL return the new write data and parity (write-first).
REQ-026 A write in a later cycle SHALL NOT alter a read already sampled.
REQ-027 Parity check: recompute even parity per nibble of the stored data and XOR it with the stored parity, giving an 8-bit syndrome.
REQ-028 rsbe SHALL be 1 iff the syndrome has exactly one bit set; rdbe SHALL be 1 iff two or more bits are set; both flags are mutually exclusive.

Reset
REQ-029 On rst_n low, SHALL immediately drive rdat=0, rpar=0, rsbe=0, rdbe=0, init_done=0, FSM=INIT, counter=0.
REQ-030 Reads in flight at reset assertion SHALL be discarded.
REQ-031 Assertion mid-INIT or mid-READY SHALL restart the full clear.
REQ-032 Memory array SHALL have no reset of its own; contents are defined solely by the INIT clear.

Configuration
REQ-033 With macro DMA_PCIE_MI_RAM_PAR_CHK_EN defined, rsbe and rdbe SHALL be generated per REQ-027 and REQ-028.
REQ-034 Without DMA_PCIE_MI_RAM_PAR_CHK_EN, rsbe and rdbe SHALL be tied to 0 and no syndrome logic is built; rpar SHALL still return the stored parity.

Verification
REQ-035 Init: release rst_n -> init_done rises exactly 2048 clocks later; a ren to 0x7FF issued in INIT -> rdat=0, rpar=0.
REQ-036 Write/read: write 0x7FF = 0xDEADBEEF with correct parity; ren at T -> rdat=0xDEADBEEF at T+2 (RD_LAT=2) and T+1 (RD_LAT=1); rsbe=rdbe=0.
REQ-037 Collision: wen and ren to 0x010 in the same cycle, wdat=0x12345678 -> read returns 0x12345678.
REQ-038 Parity (macro defined): write 0x00000000 with wpar=0x01 -> rsbe=1; with wpar=0x03 -> rdbe=1; macro undefined -> both 0.
REQ-039 Range and reset: write 0x800 = 0xFFFFFFFF, then read 0x000 -> value unchanged; read 0x800 -> 0; rst_n pulsed with 2 reads pending -> no read result emerges, and init_done=0 for 2048 clocks.

Source files
------------

// File: rtl/dma_pcie_mi_4bx2048_ram_slv_if.sv
// Port bundle for the 2048 x 32-bit RAM with nibble parity.
// The s modport is the RAM side and the m modport is the requester side.
interface dma_pcie_mi_4Bx2048_4Bwe_ram_if;
    logic [11:0] wadr;
    logic        wen;
    logic [31:0] wdat;
    logic [7:0]  wpar;
    logic        ren;
    logic [11:0] radr;
    logic [31:0] rdat;
    logic [7:0]  rpar;
    logic        rsbe;
    logic        rdbe;

    modport s (input wadr, wen, wdat, wpar, ren, radr, output rdat, rpar, rsbe, rdbe);
    modport m (output wadr, wen, wdat, wpar, ren, radr, input rdat, rpar, rsbe, rdbe);
endinterface

// File: rtl/dma_pcie_mi_4bx2048_ram_slv.sv
// 2048 x (32 data + 8 nibble parity) RAM slave that clears itself after reset, with a read latency of 1 or 2 clocks.
// Defining DMA_PCIE_MI_RAM_PAR_CHK_EN builds the parity syndrome check that drives rsbe/rdbe.
module dma_pcie_mi_4bx2048_ram_slv #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    dma_pcie_mi_4Bx2048_4Bwe_ram_if.s        ram,
    output logic                             init_done
);
    localparam int unsigned DEPTH = 2048;

    typedef enum logic {INIT, READY} state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        init_done_q, init_done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 11'd1;
            if (cnt_q == 11'h7FF) begin
                state_d     = READY;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // Single write port: the clear sequence owns it in INIT, and user writes are accepted only in READY.
    logic [39:0] mem [DEPTH];
    logic        wr_ok;
    logic        mem_we;
    logic [10:0] mem_wadr;
    logic [39:0] mem_wdat;
    logic [39:0] mem_rdat_q;

    always_comb begin
        wr_ok    = (state_q == READY) && ram.wen && !ram.wadr[11];
        mem_we   = wr_ok;
        mem_wadr = ram.wadr[10:0];
        mem_wdat = {ram.wpar, ram.wdat};
        if (state_q == INIT) begin
            mem_we   = 1'b1;
            mem_wadr = cnt_q;
            mem_wdat = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdat;
        end
        if (ram.ren) begin
            mem_rdat_q <= mem[ram.radr[10:0]];
        end
    end

    // The array read returns the old word. A same-cycle write to the same address is captured
    // alongside the read and substituted afterwards, which gives write-first behaviour.
    logic        rvld_a_q, rvld_a_d;
    logic        rzero_a_q, rzero_a_d;
    logic        byp_a_q, byp_a_d;
    logic [39:0] byp_dat_a_q, byp_dat_a_d;

    always_comb begin
        rvld_a_d    = ram.ren;
        rzero_a_d   = rzero_a_q;
        byp_a_d     = byp_a_q;
        byp_dat_a_d = byp_dat_a_q;
        if (ram.ren) begin
            rzero_a_d   = (state_q == INIT) || ram.radr[11];
            byp_a_d     = wr_ok && (ram.wadr == ram.radr);
            byp_dat_a_d = {ram.wpar, ram.wdat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvld_a_q    <= 1'b0;
            rzero_a_q   <= 1'b1;
            byp_a_q     <= 1'b0;
            byp_dat_a_q <= '0;
        end else begin
            rvld_a_q    <= rvld_a_d;
            rzero_a_q   <= rzero_a_d;
            byp_a_q     <= byp_a_d;
            byp_dat_a_q <= byp_dat_a_d;
        end
    end

    logic [39:0] a_word;
    logic        a_sbe;
    logic        a_dbe;

    always_comb begin
        a_word = mem_rdat_q;
        if (rzero_a_q) begin
            a_word = '0;
        end else if (byp_a_q) begin
            a_word = byp_dat_a_q;
        end
    end

`ifdef DMA_PCIE_MI_RAM_PAR_CHK_EN
    logic [7:0] syn;

    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            syn[i] = (^a_word[4*i +: 4]) ^ a_word[32+i];
        end
    end

    assign a_sbe = (syn != '0) && ((syn & (syn - 8'd1)) == '0);
    assign a_dbe = (syn & (syn - 8'd1)) != '0;
`else
    assign a_sbe = 1'b0;
    assign a_dbe = 1'b0;
`endif

    if (RD_LAT == 1) begin : g_lat1
        assign ram.rdat = a_word[31:0];
        assign ram.rpar = a_word[39:32];
        assign ram.rsbe = a_sbe;
        assign ram.rdbe = a_dbe;
    end else begin : g_lat2
        logic [41:0] rd_out_q, rd_out_d;

        always_comb begin
            rd_out_d = rd_out_q;
            if (rvld_a_q) begin
                rd_out_d = {a_dbe, a_sbe, a_word};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_out_q <= '0;
            end else begin
                rd_out_q <= rd_out_d;
            end
        end

        assign ram.rdat = rd_out_q[31:0];
        assign ram.rpar = rd_out_q[39:32];
        assign ram.rsbe = rd_out_q[40];
        assign ram.rdbe = rd_out_q[41];
    end

endmodule
